// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_pkg
//  Purpose  : Shared definitions for the fetch stage: opcode values,
//             instruction field positions, the bubble word and FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

  // Opcodes (instruction bits [27:24])
  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] BLE = 4'hB;
  localparam logic [3:0] JMP = 4'hC;

  // Instruction field bit positions
  localparam int OPC_MSB    = 27;
  localparam int OPC_LSB    = 24;
  localparam int DEST_MSB   = 23;
  localparam int DEST_LSB   = 16;
  localparam int TARGET_MSB = DEST_MSB;
  localparam int TARGET_LSB = DEST_LSB;
  localparam int SRC1_MSB   = 15;
  localparam int SRC1_LSB   = 8;
  localparam int SRC0_MSB   = 7;
  localparam int SRC0_LSB   = 0;

  // A bubble is the all-zero word, which decodes as NOP downstream
  localparam logic [27:0] NOP_WORD = 28'd0;

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_if
//  Purpose  : Bundles the fetch stage's ROM, control and IF/ID signals.
//  Ports    : master - the fetch stage (drives oAddress and the IF/ID outputs)
//             slave  - environment (ROM data, stall, branch redirect)
//  Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH   = 16,
  parameter int INSN_WIDTH   = 28,
  parameter int TARGET_WIDTH = 8,
  parameter int CNT_WIDTH    = 16
);

  logic [ADDR_WIDTH-1:0]   oAddress;
  logic [INSN_WIDTH-1:0]   iInstruction;
  logic                    iStall;
  logic                    iBranchTaken;
  logic [TARGET_WIDTH-1:0] iBranchTarget;
  logic [INSN_WIDTH-1:0]   oInstruction;
  logic [ADDR_WIDTH-1:0]   oPC;
  logic                    oValid;
  logic [CNT_WIDTH-1:0]    oBubbleCount;

  modport master (
    output oAddress, oInstruction, oPC, oValid, oBubbleCount,
    input  iInstruction, iStall, iBranchTaken, iBranchTarget
  );

  modport slave (
    input  oAddress, oInstruction, oPC, oValid, oBubbleCount,
    output iInstruction, iStall, iBranchTaken, iBranchTarget
  );

endinterface : instruction_fetch_if
`default_nettype wire

// File: rtl/instruction_fetch_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_if_id_reg
//  Purpose  : IF/ID pipeline register holding instruction, its address and
//             a valid flag. Flush loads a bubble, load captures, else hold.
//  Ports    : clk, rst_n         - clock, async active-low reset
//             load, flush        - capture / bubble controls (flush wins)
//             insn_in, pc_in     - fetched instruction and its address
//             insn_out, pc_out,
//             valid_out          - registered IF/ID contents
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter int              ADDR_WIDTH = 16,
  parameter int              INSN_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  flush,
  input  logic [INSN_WIDTH-1:0] insn_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  valid_out
);

  logic [INSN_WIDTH-1:0] insn_q, insn_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;

  always_comb begin
    insn_d  = insn_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      // Bubble: address field is left as-is, it carries no meaning when invalid
      insn_d  = INSN_WIDTH'(NOP_WORD);
      valid_d = 1'b0;
    end else if (load) begin
      insn_d  = insn_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn_q  <= INSN_WIDTH'(NOP_WORD);
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign insn_out  = insn_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

endmodule : instruction_fetch_if_id_reg
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Fetch stage. Owns the PC, drives the zero-latency ROM, captures
//             the returned word into IF/ID, handles stall, branch flush and
//             in-fetch JMP redirect, and counts inserted bubbles.
//  Ports    : Clock - rising-edge clock
//             Reset - asynchronous active-low reset
//             bus   - instruction_fetch_if.master (ROM address/data, stall,
//                     branch redirect, IF/ID outputs, bubble counter)
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    INSN_WIDTH   = 28,
  parameter int                    TARGET_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter int                    CNT_WIDTH    = 16
) (
  input logic                 Clock,
  input logic                 Reset,
  instruction_fetch_if.master bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                    w_load;
  logic                    w_flush;
  logic                    w_bump;
  logic [3:0]              w_opcode;
  logic [TARGET_WIDTH-1:0] w_jmp_target;

  assign w_opcode     = bus.iInstruction[OPC_MSB:OPC_LSB];
  assign w_jmp_target = bus.iInstruction[TARGET_LSB +: TARGET_WIDTH];

  // Next PC, IF/ID control and FSM transition. Branch beats stall beats JMP.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w_load  = 1'b0;
    w_flush = 1'b0;
    w_bump  = 1'b0;
    case (state_q)
      S_BOOT: begin
        // One settling cycle for the ROM address; this bubble is not counted
        w_flush = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.iBranchTaken) begin
          pc_d    = {{(ADDR_WIDTH-TARGET_WIDTH){1'b0}}, bus.iBranchTarget};
          w_flush = 1'b1;
          w_bump  = 1'b1;
        end else if (bus.iStall) begin
          pc_d = pc_q;
        end else if (w_opcode == JMP) begin
          // JMP is resolved here and never reaches decode
          pc_d    = {{(ADDR_WIDTH-TARGET_WIDTH){1'b0}}, w_jmp_target};
          w_flush = 1'b1;
          w_bump  = 1'b1;
        end else begin
          pc_d   = pc_q + ADDR_WIDTH'(1);
          w_load = 1'b1;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Bubble counter sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (w_bump && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  instruction_fetch_if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSN_WIDTH (INSN_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_if_id_reg (
    .clk       (Clock),
    .rst_n     (Reset),
    .load      (w_load),
    .flush     (w_flush),
    .insn_in   (bus.iInstruction),
    .pc_in     (pc_q),
    .insn_out  (bus.oInstruction),
    .pc_out    (bus.oPC),
    .valid_out (bus.oValid)
  );

  assign bus.oAddress     = pc_q;
  assign bus.oBubbleCount = cnt_q;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Directed self-checking bench for instruction_fetch. Instance 1
//             uses default parameters; instance 2 starts at 16'hFFFE with a
//             2-bit bubble counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic Clock;
  logic Reset;
  logic Reset2;

  int checks = 0;
  int errors = 0;

  logic       stall1, br1, force_jmp1;
  logic [7:0] tgt1;
  logic       stall2, br2;
  logic [7:0] tgt2;

  instruction_fetch_if #(.CNT_WIDTH(16)) bus1 ();
  instruction_fetch_if #(.CNT_WIDTH(2))  bus2 ();

  // ROM: default word is opcode 1 with the address in the low half
  function automatic logic [27:0] rom_read(input logic [15:0] a);
    logic [27:0] w;
    case (a)
      16'd1:   w = 28'h1000005;
      16'd14:  w = {JMP, 8'd2, 16'd0};
      default: w = {4'h1, 8'h00, a};
    endcase
    return w;
  endfunction

  assign bus1.iInstruction  = force_jmp1 ? {JMP, 8'd9, 16'd0} : rom_read(bus1.oAddress);
  assign bus1.iStall        = stall1;
  assign bus1.iBranchTaken  = br1;
  assign bus1.iBranchTarget = tgt1;
  assign bus2.iInstruction  = rom_read(bus2.oAddress);
  assign bus2.iStall        = stall2;
  assign bus2.iBranchTaken  = br2;
  assign bus2.iBranchTarget = tgt2;

  instruction_fetch #(.CNT_WIDTH(16)) dut1 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus1)
  );

  instruction_fetch #(.RESET_PC(16'hFFFE), .CNT_WIDTH(2)) dut2 (
    .Clock (Clock),
    .Reset (Reset2),
    .bus   (bus2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) tick();
    checks++; if (bus1.oAddress !== 16'd0) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus1.oAddress); end
    checks++; if (bus1.oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus1.oValid); end
    checks++; if (bus1.oInstruction !== 28'd0) begin errors++; $display("FAIL reset_insn: got %h want 0", bus1.oInstruction); end
    checks++; if (bus1.oPC !== 16'd0) begin errors++; $display("FAIL reset_pc: got %h want 0000", bus1.oPC); end
    checks++; if (bus1.oBubbleCount !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus1.oBubbleCount); end
    Reset = 1'b1;
    tick();  // boot bubble
    checks++; if (bus1.oValid !== 1'b0 || bus1.oAddress !== 16'd0) begin errors++; $display("FAIL boot_bubble: valid %b addr %h want 0 0000", bus1.oValid, bus1.oAddress); end
    tick();
    checks++; if (bus1.oInstruction !== 28'h1000000 || bus1.oPC !== 16'd0 || bus1.oValid !== 1'b1) begin errors++; $display("FAIL first_fetch: insn %h pc %h v %b want 1000000 0000 1", bus1.oInstruction, bus1.oPC, bus1.oValid); end
    tick();
    checks++; if (bus1.oInstruction !== 28'h1000005 || bus1.oPC !== 16'd1) begin errors++; $display("FAIL second_fetch: insn %h pc %h want 1000005 0001", bus1.oInstruction, bus1.oPC); end
    checks++; if (bus1.oAddress !== 16'd2) begin errors++; $display("FAIL second_addr: got %h want 0002", bus1.oAddress); end
    checks++; if (bus1.oBubbleCount !== 16'd0) begin errors++; $display("FAIL boot_not_counted: got %0d want 0", bus1.oBubbleCount); end
  endtask

  task automatic test_stall();
    repeat (2) tick();  // PC 2 -> 4
    checks++; if (bus1.oAddress !== 16'd4) begin errors++; $display("FAIL pre_stall_addr: got %h want 0004", bus1.oAddress); end
    stall1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus1.oAddress !== 16'd4 || bus1.oPC !== 16'd3 || bus1.oInstruction !== 28'h1000003 || bus1.oValid !== 1'b1 || bus1.oBubbleCount !== 16'd0) begin
        errors++; $display("FAIL stall_hold[%0d]: addr %h pc %h insn %h v %b cnt %0d want 0004 0003 1000003 1 0", i, bus1.oAddress, bus1.oPC, bus1.oInstruction, bus1.oValid, bus1.oBubbleCount);
      end
    end
    stall1 = 1'b0;
    tick();
    checks++; if (bus1.oInstruction !== 28'h1000004 || bus1.oPC !== 16'd4 || bus1.oAddress !== 16'd5) begin errors++; $display("FAIL stall_release: insn %h pc %h addr %h want 1000004 0004 0005", bus1.oInstruction, bus1.oPC, bus1.oAddress); end
  endtask

  task automatic test_jmp();
    for (int i = 0; i < 32 && bus1.oAddress !== 16'd14; i++) tick();
    checks++; if (bus1.oAddress !== 16'd14) begin errors++; $display("FAIL reach_jmp: got %h want 000e", bus1.oAddress); end
    tick();
    checks++; if (bus1.oAddress !== 16'd2 || bus1.oValid !== 1'b0 || bus1.oInstruction !== 28'd0) begin errors++; $display("FAIL jmp_redirect: addr %h v %b insn %h want 0002 0 0", bus1.oAddress, bus1.oValid, bus1.oInstruction); end
    checks++; if (bus1.oBubbleCount !== 16'd1) begin errors++; $display("FAIL jmp_count: got %0d want 1", bus1.oBubbleCount); end
    tick();
    checks++; if (bus1.oInstruction !== 28'h1000002 || bus1.oPC !== 16'd2 || bus1.oValid !== 1'b1 || bus1.oAddress !== 16'd3) begin errors++; $display("FAIL jmp_target_fetch: insn %h pc %h v %b addr %h want 1000002 0002 1 0003", bus1.oInstruction, bus1.oPC, bus1.oValid, bus1.oAddress); end
  endtask

  task automatic test_branch_priority();
    stall1 = 1'b1; br1 = 1'b1; tgt1 = 8'd5; force_jmp1 = 1'b1;
    tick();
    stall1 = 1'b0; br1 = 1'b0; tgt1 = 8'd0; force_jmp1 = 1'b0;
    checks++; if (bus1.oAddress !== 16'd5) begin errors++; $display("FAIL branch_wins: addr %h want 0005", bus1.oAddress); end
    checks++; if (bus1.oValid !== 1'b0 || bus1.oInstruction !== 28'd0) begin errors++; $display("FAIL branch_bubble: v %b insn %h want 0 0", bus1.oValid, bus1.oInstruction); end
    checks++; if (bus1.oBubbleCount !== 16'd2) begin errors++; $display("FAIL branch_count: got %0d want 2", bus1.oBubbleCount); end
    tick();
    checks++; if (bus1.oInstruction !== 28'h1000005 || bus1.oPC !== 16'd5 || bus1.oValid !== 1'b1) begin errors++; $display("FAIL branch_target_fetch: insn %h pc %h v %b want 1000005 0005 1", bus1.oInstruction, bus1.oPC, bus1.oValid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8 && bus1.oAddress !== 16'd9; i++) tick();
    checks++; if (bus1.oAddress !== 16'd9) begin errors++; $display("FAIL reach_pc9: got %h want 0009", bus1.oAddress); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (bus1.oAddress !== 16'd0 || bus1.oValid !== 1'b0 || bus1.oInstruction !== 28'd0 || bus1.oBubbleCount !== 16'd0) begin
      errors++; $display("FAIL async_reset: addr %h v %b insn %h cnt %0d want 0000 0 0 0", bus1.oAddress, bus1.oValid, bus1.oInstruction, bus1.oBubbleCount);
    end
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    checks++; if (bus1.oValid !== 1'b0 || bus1.oAddress !== 16'd0) begin errors++; $display("FAIL reboot_bubble: v %b addr %h want 0 0000", bus1.oValid, bus1.oAddress); end
    tick();
    checks++; if (bus1.oValid !== 1'b1 || bus1.oPC !== 16'd0 || bus1.oAddress !== 16'd1) begin errors++; $display("FAIL reboot_fetch: v %b pc %h addr %h want 1 0000 0001", bus1.oValid, bus1.oPC, bus1.oAddress); end
  endtask

  task automatic test_wrap_saturate();
    logic [1:0] exp_cnt;
    Reset2 = 1'b0;
    tick();
    checks++; if (bus2.oAddress !== 16'hFFFE || bus2.oPC !== 16'hFFFE || bus2.oBubbleCount !== 2'd0) begin errors++; $display("FAIL wrap_reset: addr %h pc %h cnt %0d want fffe fffe 0", bus2.oAddress, bus2.oPC, bus2.oBubbleCount); end
    @(negedge Clock);
    Reset2 = 1'b1;
    tick();  // boot bubble
    tick();
    checks++; if (bus2.oPC !== 16'hFFFE || bus2.oValid !== 1'b1) begin errors++; $display("FAIL wrap_pc0: pc %h v %b want fffe 1", bus2.oPC, bus2.oValid); end
    tick();
    checks++; if (bus2.oPC !== 16'hFFFF || bus2.oInstruction !== 28'h100FFFF) begin errors++; $display("FAIL wrap_pc1: pc %h insn %h want ffff 100ffff", bus2.oPC, bus2.oInstruction); end
    tick();
    checks++; if (bus2.oPC !== 16'h0000 || bus2.oAddress !== 16'h0001) begin errors++; $display("FAIL wrap_pc2: pc %h addr %h want 0000 0001", bus2.oPC, bus2.oAddress); end
    br2 = 1'b1; tgt2 = 8'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++; if (bus2.oBubbleCount !== exp_cnt || bus2.oAddress !== 16'd7) begin errors++; $display("FAIL saturate[%0d]: cnt %0d addr %h want %0d 0007", i, bus2.oBubbleCount, bus2.oAddress, exp_cnt); end
    end
    br2 = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; Reset2 = 1'b0;
    stall1 = 1'b0; br1 = 1'b0; tgt1 = 8'd0; force_jmp1 = 1'b0;
    stall2 = 1'b0; br2 = 1'b0; tgt2 = 8'd0;
    test_reset();
    test_stall();
    test_jmp();
    test_branch_priority();
    test_async_reset();
    test_wrap_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
